sender_fifo: RTL

//  Parametrised successor to the single-word four-phase sender.
//  - Buffers up to DEPTH words from the local producer in a FIFO.
//  - Drains the words in order over a Request/Ack four-phase handshake.
//  - Optional Ack timeout: the word is re-requested and a sticky error flag is raised.
//  - Sits between the local data source and the receiver side of the link.

---
 rtl/sender_fifo.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sender_fifo.sv
// sender_fifo: buffers up to DEPTH words from a local producer and drains
// them in order over a four-phase Request/Ack handshake, with an optional
// Ack timeout that re-requests the word and raises a sticky Error flag.
module sender_fifo #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   Transmit,
  input  logic [WIDTH-1:0]       sdrDataIn,
  input  logic                   Ack,
  output logic                   Ready,
  output logic                   Request,
  output logic [WIDTH-1:0]       sdrDataOut,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAITLO = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_data_out;
  logic             r_request;
  logic             r_error;
  logic             w_push;
  logic             w_load;
  logic             w_pop;
  logic             w_tmo;
  logic             w_tmo_hit;

  // Ready looks at the pre-edge count, so a pop on the same edge cannot free a slot.
  assign Ready  = (r_count != FULL_COUNT);
  assign w_push = Transmit & Ready;

  assign Request    = r_request;
  assign sdrDataOut = r_data_out;
  assign Count      = r_count;
  assign Error      = r_error;

  if (TIMEOUT > 0) begin : g_tmo
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo_cnt;

    // Count cycles spent in REQ without Ack; cleared on REQ entry, saturating.
    always_ff @(posedge clk) begin
      if (!Reset) begin
        r_tmo_cnt <= '0;
      end else if (w_load) begin
        r_tmo_cnt <= '0;
      end else if (r_state == ST_REQ && r_tmo_cnt != TW'(TIMEOUT)) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
    end

    assign w_tmo_hit = (r_state == ST_REQ) && (r_tmo_cnt == TW'(TIMEOUT - 1));
  end else begin : g_no_tmo
    assign w_tmo_hit = 1'b0;
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes; Ack has priority over a timeout in REQ.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pop       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0 && !Ack) begin
          w_load      = 1'b1;
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (Ack) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WAITLO;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAITLO: begin
        if (!Ack) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAITLO;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Storage write at the tail; contents need no reset since pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= sdrDataIn;
    end
  end

  // Pointers and occupancy; full/empty comes from the count, pointers just wrap.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered link outputs: word and Request load together, Error is sticky.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_request  <= 1'b0;
      r_data_out <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_load) begin
        r_request  <= 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end else if (w_pop || w_tmo) begin
        r_request  <= 1'b0;
      end
      if (w_tmo) begin
        r_error <= 1'b1;
      end
    end
  end

endmodule
